// File: rtl/fetch_unit_if.sv
// Instruction memory read port: word request/acknowledge handshake.
interface fetch_unit_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads for the current PC, presents the
// returned instruction to decode, parks one response in a skid register while
// decode stalls, and drops in-flight data when a branch redirects the PC.
module fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_IR = 32'h0000_0013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              redirect,
  input  logic              stall,
  fetch_unit_if.master      mem,
  output logic              pc_en,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] instr_pc_out,
  output logic              instr_valid,
  output logic              fetch_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ir_pc;
  logic              ir_valid;
  logic [DATA_W-1:0] skid;
  logic [DATA_W-1:0] skid_pc;
  logic              skid_valid;

  // Decoded actions for the current cycle.
  logic              issue;      // latch pc_in as the next request address
  logic              load_ack;   // acked word goes straight to the IR
  logic              load_skid;  // acked word parked while decode stalls
  logic              load_hold;  // parked word moves into the IR

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath-action decode.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    load_ack   = 1'b0;
    load_skid  = 1'b0;
    load_hold  = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && !stall) begin
          if (pc_in[1:0] != 2'b00) begin
            state_next = FAULT;
          end else begin
            state_next = REQ;
            issue      = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          if (redirect) begin
            state_next = IDLE;
          end else if (stall) begin
            state_next = HOLD;
            load_skid  = 1'b1;
          end else begin
            load_ack   = 1'b1;
          end
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next = IDLE;
        end else if (!stall) begin
          state_next = IDLE;
          load_hold  = skid_valid;
        end
      end
      DRAIN: begin
        // Request must stay up until the outstanding ack; its data is dropped.
        if (mem.mem_ack) begin
          state_next = IDLE;
        end
      end
      FAULT: begin
        if (redirect) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs plus the combinational PC update enable.
  always_comb begin
    mem.mem_req = (state == REQ) || (state == DRAIN);
    fetch_fault = (state == FAULT);
    pc_en       = redirect || ((state == REQ) && mem.mem_ack);
  end

  // Request address and instruction register.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_addr <= '0;
      ir       <= RESET_IR;
      ir_pc    <= '0;
    end else begin
      if (issue) begin
        req_addr <= pc_in;
      end else if (load_ack) begin
        req_addr <= req_addr + DATA_W'(4);
      end
      if (load_ack) begin
        ir    <= mem.mem_rdata;
        ir_pc <= req_addr;
      end else if (load_hold) begin
        ir    <= skid;
        ir_pc <= skid_pc;
      end
    end
  end

  // Skid register data: only meaningful while skid_valid is set.
  always_ff @(posedge clock) begin
    if (load_skid) begin
      skid    <= mem.mem_rdata;
      skid_pc <= req_addr;
    end
  end

  // Valid flags: a redirect kills anything from the wrong path first.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (redirect) begin
        ir_valid <= 1'b0;
      end else if (load_ack || load_hold) begin
        ir_valid <= 1'b1;
      end else if (!stall) begin
        ir_valid <= 1'b0;
      end

      if (redirect) begin
        skid_valid <= 1'b0;
      end else if (load_skid) begin
        skid_valid <= 1'b1;
      end else if (load_hold) begin
        skid_valid <= 1'b0;
      end
    end
  end

  assign mem.mem_addr  = req_addr;
  assign instr_out     = ir;
  assign instr_pc_out  = ir_pc;
  assign instr_valid   = ir_valid;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the program counter. Takes the current PC and issues word reads to instruction memory over a req/ack handshake. Presents the returned instruction and its PC to decode, and drives the PC's update enable. Holds one in-flight response in a skid register while decode stalls, and discards in-flight data on a branch redirect.

## Interface
- RESET_IR, 32'h0000_0013, instruction register value after reset (RV32 NOP).
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  32  current PC from the PC stage.
- redirect  input  1  branch taken this cycle; the PC stage loads the target when pc_en is high.
- stall  input  1  decode cannot accept an instruction this cycle.
- mem_req  output  1  instruction read request.
- mem_addr  output  32  registered word address of the request.
- mem_ack  input  1  read data valid; one-cycle pulse.
- mem_rdata  input  32  read data, valid with mem_ack.
- pc_en  output  1  update enable to the PC stage (combinational).
- instr_out  output  32  instruction register.
- instr_pc_out  output  32  PC of instr_out.
- instr_valid  output  1  instr_out holds a live instruction.
- fetch_fault  output  1  misaligned PC detected; fetch halted.

## Operation
- States: IDLE, REQ, HOLD, DRAIN, FAULT. Registers: req_addr, ir, ir_pc, ir_valid, skid, skid_pc, skid_valid.
- mem_req = (state==REQ || state==DRAIN). mem_addr = req_addr. fetch_fault = (state==FAULT).
- pc_en = redirect | (state==REQ & mem_ack).
- Memory rule: once mem_req rises, req and mem_addr are held unchanged until mem_ack.
- IDLE:
  - redirect → stay IDLE.
  - else if !stall and pc_in[1:0]!=0 → FAULT.
  - else if !stall → req_addr<=pc_in, go to REQ.
- REQ:
  - ack with redirect → discard data, go to IDLE.
  - ack with stall → skid<=mem_rdata, skid_pc<=req_addr, skid_valid<=1, go to HOLD.
  - ack with neither → ir<=mem_rdata, ir_pc<=req_addr, ir_valid<=1, req_addr<=req_addr+4, stay REQ (back-to-back).
  - redirect without ack → go to DRAIN.
- DRAIN:
  - ack → discard data, go to IDLE.
  - redirect → stay DRAIN.
- HOLD:
  - redirect → go to IDLE.
  - else if !stall → ir<=skid, ir_pc<=skid_pc, ir_valid<=1, skid_valid<=0, go to IDLE.
- FAULT:
  - redirect → go to IDLE.
  - otherwise remain in FAULT.
- ir_valid priority: redirect clears it → load sets it → !stall clears it (consumed) → else hold.
- redirect clears skid_valid.
- req_addr+4 wraps modulo 2^32.

## Timing
- Reset values: state IDLE, req_addr 0, ir RESET_IR, ir_pc 0, ir_valid 0, skid_valid 0. Outputs: mem_req 0, fetch_fault 0, instr_valid 0.
- pc_en is 0 during reset unless redirect is high.
- Reset mid-request abandons the transaction; the memory must tolerate mem_req dropping.
- The first request is issued in the cycle after the IDLE issue decision, so mem_req is first high the 2nd cycle after reset deasserts.
- Same-cycle ack: 1 instruction/cycle sustained. Each ack raises instr_valid on the next edge.
- An N-cycle ack gives N-cycle spacing between instructions.
- On stall at ack: the instruction appears 1 cycle after stall falls, then a new request issues the following cycle.
- Redirect: pc_en in the same cycle. In the next cycle, no instruction is valid from the wrong path.

## Test plan
- Reset, pc_in=0x0 with PC stepping by 4, same-cycle ack returning 0x11,0x22,0x33 → mem_addr 0x0,0x4,0x8 on consecutive cycles; instr_out 0x11/0x22/0x33 with instr_pc_out 0x0/0x4/0x8; pc_en high each ack cycle.
- 3-cycle ack latency → mem_req and mem_addr stable for 3 cycles; one pc_en pulse per ack; instr_valid high for one cycle per fetch.
- stall high when ack returns 0xAA at 0x10 → state HOLD, instr_out unchanged. On stall drop, instr_out=0xAA and instr_pc_out=0x10 next cycle; next request to 0x14.
- redirect in REQ with ack pending 2 cycles, pc_in becoming 0x100 → DRAIN; mem_addr held; the acked data is never presented; the next request is to 0x100.
- redirect coincident with ack → pc_en=1, data discarded, instr_valid=0 next cycle.
- pc_in=0x102 in IDLE → fetch_fault=1, mem_req=0. Redirect to 0x200 → fetch_fault clears and a request to 0x200 issues. Reset while in FAULT → all outputs at reset values.
